dct_basis_gen: RTL

Parametrised 2-D DCT basis-term generator for the FPGA DCT datapath. It replaces the per-(k1,k2) hard-coded cosine lookup modules with one block. The block accepts any frequency pair (k1,k2) on a request handshake and streams all N×N signed fixed-point terms α(k1)α(k2)·cos((2n1+1)k1π/2N)·cos((2n2+1)k2π/2N), one per cycle, with valid/ready backpressure. It sits between the DCT controller and the multiply-accumulate stage.

---
 rtl/dct_pkg.sv | 62 ++++++
 rtl/dct_cos1d_rom.sv | 43 ++++
 rtl/dct_basis_gen.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: shared constants, FSM state type and the quarter-wave
// 1-D cosine tables (FRAC_1D=14) for the DCT basis generator.
package dct_pkg;

  localparam int N_DEFAULT        = 8;
  localparam int FRAC_1D_DEFAULT  = 14;
  localparam int OUT_FRAC_DEFAULT = 10;
  localparam int C_W              = FRAC_1D_DEFAULT + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef logic signed [C_W-1:0] coef_t;

  // round(2^14 * sqrt(2/N) * cos(m*pi/2N)), m = 0..N
  localparam coef_t Q4 [5] = '{
    16'sd11585, 16'sd10703, 16'sd8192, 16'sd4433, 16'sd0
  };

  localparam coef_t Q8 [9] = '{
    16'sd8192, 16'sd8035, 16'sd7568, 16'sd6811, 16'sd5793,
    16'sd4551, 16'sd3135, 16'sd1598, 16'sd0
  };

  localparam coef_t Q16 [17] = '{
    16'sd5793, 16'sd5765, 16'sd5681, 16'sd5543, 16'sd5352,
    16'sd5109, 16'sd4816, 16'sd4478, 16'sd4096, 16'sd3675,
    16'sd3218, 16'sd2731, 16'sd2217, 16'sd1682, 16'sd1130,
    16'sd568,  16'sd0
  };

  // Quarter-wave magnitude for block size nsz at angle step m.
  function automatic coef_t qw_coef(input int nsz,
                                    input logic [4:0] m);
    coef_t v;
    v = '0;
    case (nsz)
      4:       v = Q4[m[2:0]];
      8:       v = Q8[m[3:0]];
      16:      v = Q16[m];
      default: v = '0;
    endcase
    return v;
  endfunction

  // DC row: round(2^14 * sqrt(1/N)).
  function automatic coef_t dc_coef(input int nsz);
    coef_t v;
    v = '0;
    case (nsz)
      4:       v = 16'sd8192;
      8:       v = 16'sd5793;
      16:      v = 16'sd4096;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dct_cos1d_rom.sv
// dct_cos1d_rom: registered 1-D coefficient c[k][n], built by
// folding the angle (2n+1)k mod 4N onto a quarter-wave table.
module dct_cos1d_rom
  import dct_pkg::*;
#(
  parameter int  N  = N_DEFAULT,
  localparam int KW = $clog2(N),
  localparam int AW = KW + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [KW-1:0] i_k,
  input  logic [KW-1:0] i_n,
  output coef_t         o_c
);

  logic [AW-1:0] w_a;
  logic [KW-1:0] w_r;
  logic [KW:0]   w_m;
  logic          w_neg;
  coef_t         w_mag;
  coef_t         w_c;

  assign w_a   = AW'({i_n, 1'b1}) * AW'(i_k);
  assign w_r   = w_a[KW-1:0];
  assign w_neg = w_a[AW-1] ^ w_a[AW-2];
  assign w_m   = w_a[AW-2] ? (KW+1)'(N) - {1'b0, w_r}
                           : {1'b0, w_r};
  assign w_mag = qw_coef(N, 5'(w_m));
  assign w_c   = (i_k == '0) ? dc_coef(N)
                             : (w_neg ? -w_mag : w_mag);

  // Coefficient register, advances with the pipeline enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_c <= '0;
    end else if (i_en) begin
      o_c <= w_c;
    end
  end

endmodule

// File: rtl/dct_basis_gen.sv
// dct_basis_gen: streams the N*N 2-D DCT basis terms of one (k1,k2)
// request through issue, ROM, multiply and round/output registers.
module dct_basis_gen
  import dct_pkg::*;
#(
  parameter int  N        = N_DEFAULT,
  parameter int  FRAC_1D  = FRAC_1D_DEFAULT,
  parameter int  OUT_FRAC = OUT_FRAC_DEFAULT,
  parameter int  OUT_W    = 32,
  localparam int KW       = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [KW-1:0]           req_k1,
  input  logic [KW-1:0]           req_k2,
  input  logic                    req_col_major,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] cos_term,
  output logic [KW-1:0]           out_n1,
  output logic [KW-1:0]           out_n2,
  output logic                    out_last
);

  localparam int S  = 2 * FRAC_1D - OUT_FRAC;
  localparam int PW = 2 * C_W;
  localparam logic [PW-1:0] RND = PW'(1) << (S - 1);

  state_t r_state, w_next;

  logic            w_en, w_accept, w_issue, w_idx_last;
  logic [2*KW-1:0] r_idx;
  logic [KW-1:0]   r_k1, r_k2;
  logic            r_col;
  logic [KW-1:0]   w_hi, w_lo, w_n1, w_n2;

  logic            r_v0, r_last0;
  logic [KW-1:0]   r_n1_0, r_n2_0;
  logic            r_v1, r_last1;
  logic [KW-1:0]   r_n1_1, r_n2_1;
  coef_t           w_c1, w_c2;
  logic            r_v2, r_last2;
  logic [KW-1:0]   r_n1_2, r_n2_2;
  logic signed [PW-1:0] r_p;

  logic [PW-1:0]        w_abs, w_mag;
  logic signed [PW-1:0] w_sgn;

  assign w_en       = !out_valid || out_ready;
  assign req_ready  = (r_state == IDLE) && !rst;
  assign w_accept   = req_valid && req_ready;
  assign w_issue    = (r_state == RUN) && w_en;
  assign w_idx_last = &r_idx;

  assign w_hi = r_idx[2*KW-1:KW];
  assign w_lo = r_idx[KW-1:0];
  assign w_n1 = r_col ? w_lo : w_hi;
  assign w_n2 = r_col ? w_hi : w_lo;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: accept, sweep, wait for last accept.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_issue && w_idx_last) w_next = DRAIN;
      DRAIN:   if (out_valid && out_ready && out_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch and index counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      r_k1  <= '0;
      r_k2  <= '0;
      r_col <= 1'b0;
    end else if (w_accept) begin
      r_idx <= '0;
      r_k1  <= req_k1;
      r_k2  <= req_k2;
      r_col <= req_col_major;
    end else if (w_issue) begin
      r_idx <= r_idx + (2*KW)'(1);
    end
  end

  // Issue register and ROM-stage sideband.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0    <= 1'b0;
      r_last0 <= 1'b0;
      r_n1_0  <= '0;
      r_n2_0  <= '0;
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_n1_1  <= '0;
      r_n2_1  <= '0;
    end else if (w_en) begin
      r_v0    <= (r_state == RUN);
      r_last0 <= w_idx_last;
      r_n1_0  <= w_n1;
      r_n2_0  <= w_n2;
      r_v1    <= r_v0;
      r_last1 <= r_last0;
      r_n1_1  <= r_n1_0;
      r_n2_1  <= r_n2_0;
    end
  end

  dct_cos1d_rom #(.N(N)) u_rom1 (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_en),
    .i_k  (r_k1),
    .i_n  (r_n1_0),
    .o_c  (w_c1)
  );

  dct_cos1d_rom #(.N(N)) u_rom2 (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_en),
    .i_k  (r_k2),
    .i_n  (r_n2_0),
    .o_c  (w_c2)
  );

  // Full-precision product stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      r_n1_2  <= '0;
      r_n2_2  <= '0;
      r_p     <= '0;
    end else if (w_en) begin
      r_v2    <= r_v1;
      r_last2 <= r_last1;
      r_n1_2  <= r_n1_1;
      r_n2_2  <= r_n2_1;
      r_p     <= PW'(w_c1) * PW'(w_c2);
    end
  end

  // Round magnitude half-up so mirrored terms negate exactly.
  assign w_abs = r_p[PW-1] ? unsigned'(-r_p) : unsigned'(r_p);
  assign w_mag = (w_abs + RND) >> S;
  assign w_sgn = r_p[PW-1] ? -signed'(w_mag) : signed'(w_mag);

  // Output register, frozen while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_n1    <= '0;
      out_n2    <= '0;
      cos_term  <= '0;
    end else if (w_en) begin
      out_valid <= r_v2;
      out_last  <= r_last2;
      out_n1    <= r_n1_2;
      out_n2    <= r_n2_2;
      cos_term  <= OUT_W'(w_sgn);
    end
  end

endmodule
